// File: rtl/data_mem_responder_pkg.sv
// Shared types for the data-memory responder: store-kind encodings, FSM states
// and the alignment rule used when DMEM_MISALIGN_TRAP_EN is defined.
package data_mem_responder_pkg;

  typedef enum logic [1:0] {
    MW_NONE = 2'b00,
    MW_WORD = 2'b01,
    MW_HALF = 2'b10,
    MW_BYTE = 2'b11
  } mem_write_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // A word needs Address[1:0]=00 and a halfword needs Address[0]=0.
  // Bytes are never misaligned.
  function automatic logic is_misaligned(input mem_write_t kind, input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    case (kind)
      MW_WORD: bad = (addr_lo != 2'b00);
      MW_HALF: bad = addr_lo[0];
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// MEM-stage data-memory port. The master is the pipeline MEM stage and the
// slave is the responder.
interface data_mem_responder_if;
  logic        MemRead;
  logic [1:0]  MemWrite;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        Ready;
  logic        Stall;
  logic        AlignErr;

  modport master (
    output MemRead, MemWrite, Address, WriteData,
    input  ReadData, Ready, Stall, AlignErr
  );

  modport slave (
    input  MemRead, MemWrite, Address, WriteData,
    output ReadData, Ready, Stall, AlignErr
  );
endinterface

// File: rtl/data_mem_responder_lane_merge.sv
// dmem_lane_merge: places store data into the little-endian lanes of the
// old memory word. Lanes that the store does not touch keep their contents.
module dmem_lane_merge
  import data_mem_responder_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] store_data,
  input  mem_write_t  kind,
  input  logic [1:0]  addr_lo,
  output logic [31:0] new_word
);

  // Lane selection from the store kind and the low address bits.
  // A halfword uses only Address[1], so a set Address[0] is ignored.
  always_comb begin
    new_word = old_word;
    case (kind)
      MW_WORD: new_word = store_data;
      MW_HALF: begin
        if (addr_lo[1]) new_word[31:16] = store_data[15:0];
        else            new_word[15:0]  = store_data[15:0];
      end
      MW_BYTE: begin
        case (addr_lo)
          2'd0:    new_word[7:0]   = store_data[7:0];
          2'd1:    new_word[15:8]  = store_data[7:0];
          2'd2:    new_word[23:16] = store_data[7:0];
          default: new_word[31:24] = store_data[7:0];
        endcase
      end
      default: new_word = old_word;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: wait-state data memory behind the MEM stage.
// A request seen in IDLE is held for WAIT_CYCLES cycles with Stall asserted.
// It then completes in DONE with a one-cycle Ready pulse. Writes commit and
// read data is registered on the edge that enters DONE.
// Optional feature: DMEM_MISALIGN_TRAP_EN flags misaligned halfword and word
// accesses through AlignErr and suppresses their effect. Without it,
// misaligned accesses are forced to alignment.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic            Clk,
  input  logic            Reset,
  data_mem_responder_if.slave bus
);

  localparam int         IDX_W     = $clog2(DEPTH_WORDS);
  localparam int         AW        = IDX_W + 2;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t         state, state_next;
  logic [3:0]     count, count_next;

  // Request latched in IDLE
  logic [AW-1:0]  addr_q;
  logic [31:0]    wdata_q;
  mem_write_t     kind_q;
  logic           rd_q;

  // The live request
  logic           req;
  mem_write_t     req_kind;
  logic           req_rd;

  // The access that commits on the edge into DONE
  logic [AW-1:0]  acc_addr;
  logic [31:0]    acc_data;
  mem_write_t     acc_kind;
  logic           acc_rd;
  logic           acc_bad;
  logic [IDX_W-1:0] acc_idx;
  logic           enter_done;

  logic [31:0]    mem [DEPTH_WORDS];
  logic [31:0]    old_word;
  logic [31:0]    new_word;
  logic [31:0]    read_data;
  logic           align_err;
  logic           unused_addr_bits;

  // Address bits above the index range are ignored, so accesses wrap.
  assign unused_addr_bits = ^bus.Address[31:AW];

  assign req_kind = mem_write_t'(bus.MemWrite);
  assign req      = bus.MemRead | (req_kind != MW_NONE);
  // A write takes priority when both are asserted. The read is dropped.
  assign req_rd   = bus.MemRead & (req_kind == MW_NONE);

  // With zero wait states, IDLE goes straight to DONE. The committing access is
  // then the live request rather than the latched copy.
  always_comb begin
    if (state == S_IDLE) begin
      acc_addr = bus.Address[AW-1:0];
      acc_data = bus.WriteData;
      acc_kind = req_kind;
      acc_rd   = req_rd;
    end else begin
      acc_addr = addr_q;
      acc_data = wdata_q;
      acc_kind = kind_q;
      acc_rd   = rd_q;
    end
  end

  assign acc_idx = acc_addr[AW-1:2];

`ifdef DMEM_MISALIGN_TRAP_EN
  assign acc_bad = is_misaligned(acc_kind, acc_addr[1:0]);
`else
  assign acc_bad = 1'b0;
`endif

  assign old_word = mem[acc_idx];

  dmem_lane_merge u_lane_merge (
    .old_word   (old_word),
    .store_data (acc_data),
    .kind       (acc_kind),
    .addr_lo    (acc_addr[1:0]),
    .new_word   (new_word)
  );

  // Next-state and counter logic: IDLE -> BUSY (WAIT_CYCLES cycles) -> DONE -> IDLE
  always_comb begin
    state_next = state;
    count_next = count;
    case (state)
      S_IDLE: begin
        if (req) begin
          count_next = WAIT_INIT;
          state_next = (WAIT_CYCLES == 0) ? S_DONE : S_BUSY;
        end
      end
      S_BUSY: begin
        if (count <= 4'd1) begin
          count_next = 4'd0;
          state_next = S_DONE;
        end else begin
          count_next = count - 4'd1;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  assign enter_done = (state != S_DONE) && (state_next == S_DONE);

  // State, counter, request latches and output registers
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state     <= S_IDLE;
      count     <= 4'd0;
      addr_q    <= '0;
      wdata_q   <= 32'd0;
      kind_q    <= MW_NONE;
      rd_q      <= 1'b0;
      read_data <= 32'd0;
      align_err <= 1'b0;
    end else begin
      state     <= state_next;
      count     <= count_next;
      if (state == S_IDLE && req) begin
        addr_q  <= bus.Address[AW-1:0];
        wdata_q <= bus.WriteData;
        kind_q  <= req_kind;
        rd_q    <= req_rd;
      end
      if (enter_done && acc_rd && !acc_bad) read_data <= old_word;
      align_err <= enter_done & acc_bad;
    end
  end

  // Storage write. The array is not reset, and no commit happens while Reset is low.
  always_ff @(posedge Clk) begin
    if (Reset && enter_done && (acc_kind != MW_NONE) && !acc_bad)
      mem[acc_idx] <= new_word;
  end

  assign bus.ReadData = read_data;
  assign bus.Ready    = (state == S_DONE);
  assign bus.AlignErr = align_err;
  assign bus.Stall    = Reset & (((state == S_IDLE) & req) | (state == S_BUSY));

endmodule

// File: tb/tb_data_mem_responder.sv
// Testbench for data_mem_responder: directed cases followed by randomized
// transactions. Results are compared against a word-array reference model.
module tb_data_mem_responder;

  localparam int WAIT  = 2;
  localparam int DEPTH = 1024;
`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  data_mem_responder_if bus();

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAIT)) dut (
    .Clk   (clk),
    .Reset (rst_n),
    .bus   (bus)
  );

  logic [31:0] model_mem [DEPTH];
  logic [31:0] exp_rd;
  int n_vec = 0;
  int n_miscmp = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: applies one access to the word array using the lane rules.
  task automatic model_apply(input logic rd, input logic [1:0] wr, input logic [31:0] addr,
                             input logic [31:0] data, output bit bad);
    int unsigned idx;
    int unsigned sh;
    logic [31:0] mask;
    idx = (addr >> 2) % DEPTH;
    bad = TRAP && ((wr == 2'b01 && addr[1:0] != 2'b00) ||
                   (wr == 2'b10 && addr[0]) ||
                   (wr == 2'b00 && rd && 1'b0));
    if (wr != 2'b00) begin
      if (!bad) begin
        if (wr == 2'b01) begin
          model_mem[idx] = data;
        end else if (wr == 2'b10) begin
          sh   = 16 * addr[1];
          mask = 32'h0000_FFFF << sh;
          model_mem[idx] = (model_mem[idx] & ~mask) | ((data & 32'h0000_FFFF) << sh);
        end else begin
          sh   = 8 * addr[1:0];
          mask = 32'h0000_00FF << sh;
          model_mem[idx] = (model_mem[idx] & ~mask) | ((data & 32'h0000_00FF) << sh);
        end
      end
    end else if (rd) begin
      exp_rd = model_mem[idx];
    end
  endtask

  // Runs one request. It starts and ends one time unit after a rising edge with the DUT in IDLE.
  task automatic txn(input logic rd, input logic [1:0] wr, input logic [31:0] addr,
                     input logic [31:0] data, input string name);
    bit bad;
    model_apply(rd, wr, addr, data, bad);
    $display("txn %s rd=%0b wr=%0d addr=%h data=%h", name, rd, wr, addr, data);
    bus.MemRead = rd; bus.MemWrite = wr; bus.Address = addr; bus.WriteData = data;
    @(negedge clk);
    check_val({name, " stall_c0"}, 32'(bus.Stall), 32'd1);
    check_val({name, " ready_c0"}, 32'(bus.Ready), 32'd0);
    for (int c = 1; c <= WAIT + 1; c++) begin
      @(posedge clk); #1;
      if (c <= WAIT) begin
        // Garbage while busy must be ignored.
        bus.MemRead = 1'($urandom); bus.MemWrite = 2'($urandom);
        bus.Address = $urandom; bus.WriteData = $urandom;
      end else begin
        bus.MemRead = 1'b0; bus.MemWrite = 2'b00;
      end
      @(negedge clk);
      check_val($sformatf("%s stall_c%0d", name, c), 32'(bus.Stall), 32'(c <= WAIT));
      check_val($sformatf("%s ready_c%0d", name, c), 32'(bus.Ready), 32'(c == WAIT + 1));
      if (c == WAIT + 1) begin
        check_val({name, " rdata"}, bus.ReadData, exp_rd);
        check_val({name, " alignerr"}, 32'(bus.AlignErr), 32'(bad));
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] a;
    logic [1:0]  w;
    logic        r;
    bus.MemRead = 1'b1; bus.MemWrite = 2'b01; bus.Address = 32'h0; bus.WriteData = 32'h0;
    exp_rd = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("reset rdata", bus.ReadData, 32'd0);
    check_val("reset ready", 32'(bus.Ready), 32'd0);
    check_val("reset alignerr", 32'(bus.AlignErr), 32'd0);
    check_val("reset stall", 32'(bus.Stall), 32'd0);
    bus.MemRead = 1'b0; bus.MemWrite = 2'b00;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Fill the low 16 words so that every model entry is known.
    for (int i = 0; i < 16; i++) txn(1'b0, 2'b01, 32'(i * 4), $urandom, $sformatf("init%0d", i));

    txn(1'b0, 2'b01, 32'h10, 32'hDEADBEEF, "w_word");
    txn(1'b1, 2'b00, 32'h10, 32'h0, "r_word");
    check_val("rd_10 deadbeef", bus.ReadData, 32'hDEADBEEF);

    txn(1'b0, 2'b01, 32'h10, 32'h11223344, "w_base");
    txn(1'b0, 2'b11, 32'h12, 32'h000000AA, "w_byte");
    txn(1'b1, 2'b00, 32'h10, 32'h0, "r_byte");
    check_val("rd_10 byte", bus.ReadData, 32'h11AA3344);

    txn(1'b0, 2'b01, 32'h20, 32'h0, "w_zero");
    txn(1'b0, 2'b10, 32'h22, 32'h0000BEEF, "w_half");
    txn(1'b1, 2'b00, 32'h20, 32'h0, "r_half");
    check_val("rd_20 half", bus.ReadData, 32'hBEEF0000);

    txn(1'b1, 2'b01, 32'h4, 32'h5, "both");
    check_val("both keeps rdata", bus.ReadData, 32'hBEEF0000);
    txn(1'b1, 2'b00, 32'h4, 32'h0, "r_both");
    check_val("rd_4 both", bus.ReadData, 32'h5);

    // Reset during BUSY aborts the write.
    txn(1'b0, 2'b01, 32'h8, 32'h0, "w8_zero");
    bus.MemRead = 1'b0; bus.MemWrite = 2'b01; bus.Address = 32'h8; bus.WriteData = 32'h1;
    @(posedge clk); #1;
    bus.MemWrite = 2'b00;
    rst_n = 1'b0;
    exp_rd = 32'd0;
    #1;
    check_val("abort stall", 32'(bus.Stall), 32'd0);
    check_val("abort ready", 32'(bus.Ready), 32'd0);
    check_val("abort rdata", bus.ReadData, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < WAIT + 3; c++) begin
      @(negedge clk);
      check_val($sformatf("abort no_ready%0d", c), 32'(bus.Ready), 32'd0);
    end
    @(posedge clk); #1;
    txn(1'b1, 2'b00, 32'h8, 32'h0, "r8");
    check_val("rd_8 after abort", bus.ReadData, 32'h0);

    // Misaligned halfword store to 0x13.
    txn(1'b0, 2'b01, 32'h10, 32'h0, "w10_zero");
    txn(1'b0, 2'b10, 32'h13, 32'h0000CAFE, "w_mis_half");
    txn(1'b1, 2'b00, 32'h10, 32'h0, "r_mis_half");
    check_val("rd_10 mis_half", bus.ReadData, TRAP ? 32'h0 : 32'hCAFE0000);

    // Random traffic over 16 words, with random upper address bits that wrap.
    for (int i = 0; i < 80; i++) begin
      a = ($urandom & ~32'hFFF) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      w = 2'($urandom);
      r = (w == 2'b00) ? 1'b1 : 1'($urandom);
      txn(r, w, a, $urandom, $sformatf("rnd%0d", i));
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        check_val($sformatf("rnd%0d idle_stall", i), 32'(bus.Stall), 32'd0);
        @(posedge clk); #1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Data-memory responder on the far side of the MEM-stage memory interface. Accepts word, halfword and byte read/write requests from the MEM stage, holds them for a configurable number of wait states while asserting a pipeline stall, then commits the write or returns the read word with a one-cycle ready pulse. Sits between the MEM_STAGE data-memory port and the pipeline hazard/stall logic.

## Interface
- DEPTH_WORDS, 1024, memory depth in 32-bit words (power of two)
- WAIT_CYCLES, 2, wait states inserted before completion (0–15)
- Clk  input  1  clock, rising edge
- Reset  input  1  asynchronous, active-low reset
- MemRead  input  1  read request
- MemWrite  input  2  write request: 00 none, 01 word, 10 halfword, 11 byte
- Address  input  32  byte address; word index is Address[log2(DEPTH_WORDS)+1:2]
- WriteData  input  32  store data; sub-word stores use the low bits
- ReadData  output  32  full aligned word from the last completed read
- Ready  output  1  one-cycle completion pulse
- Stall  output  1  hold-pipeline request to the hazard unit
- AlignErr  output  1  misaligned access flag (only with DMEM_MISALIGN_TRAP_EN)

## Operation
- Request present means MemRead=1 or MemWrite≠00. If both are asserted, the write is performed and the read is ignored. ReadData is not updated in that case.
- FSM states:
  - IDLE. On a request, latch Address, WriteData and the access kind. Load the counter with WAIT_CYCLES. Go to BUSY, or to DONE if WAIT_CYCLES=0.
  - BUSY. Counter decrements each cycle. When it reaches 1, go to DONE.
  - DONE. Ready=1 for this cycle only, then return to IDLE.
- Write commit happens on the clock edge entering DONE. Lane placement is little-endian:
  - Byte k=Address[1:0] writes bits 8k+7:8k from WriteData[7:0].
  - Halfword h=Address[1] writes bits 16h+15:16h from WriteData[15:0].
  - A word write replaces all 32 bits.
  - Unwritten lanes keep their contents.
- Read: ReadData is registered on the edge entering DONE with the full addressed word. It holds until the next completed read. Sub-word extraction and sign extension belong to the pipeline, not this block.
- Address bits above the index range are ignored, so accesses wrap modulo DEPTH_WORDS.
- Memory contents are not reset.

## Timing
- Stall is combinational: 1 in IDLE when a request is present, 1 in BUSY, 0 in DONE, 0 otherwise.
- Latency: a request first seen in IDLE at cycle 0 gives Ready at cycle WAIT_CYCLES+1. Stall is high for cycles 0..WAIT_CYCLES.
- The pipeline advances at the end of the DONE cycle. The next request is sampled in IDLE on the following cycle, so back-to-back requests cost WAIT_CYCLES+2 cycles each.
- Request inputs are sampled only in IDLE. Changes during BUSY or DONE are ignored.
- Reset values: ReadData=0, Ready=0, AlignErr=0, FSM=IDLE, counter=0. Stall is forced to 0 while Reset=0.
- Reset asserted mid-operation aborts the access; a write not yet in DONE is not committed.

## Configuration
- DMEM_MISALIGN_TRAP_EN defined:
  - A halfword with Address[0]=1, or a word with Address[1:0]≠00, is a misaligned access.
  - It still runs the full wait sequence.
  - It writes nothing and leaves ReadData unchanged.
  - AlignErr=1 in the DONE cycle alongside Ready.
- Not defined:
  - Misaligned low address bits are forced to alignment: Address[0] is cleared for halfwords, Address[1:0] for words.
  - AlignErr is tied to 0.

## Structure
- Shared package holds:
  - MemWrite encodings: MW_NONE, MW_WORD, MW_HALF, MW_BYTE.
  - FSM state constants: S_IDLE, S_BUSY, S_DONE.
- One sub-module, dmem_lane_merge: combinational merge of old word, store data, kind and Address[1:0] into the new word. The top level holds the FSM, counter, latches and storage array.

## Test plan
- Reset then word write 0xDEADBEEF to 0x10, WAIT_CYCLES=2 -> Stall high for cycles 0–2, Ready pulse at cycle 3; a later word read of 0x10 returns 0xDEADBEEF.
- Byte write 0xAA to 0x12 over 0x11223344 -> read of 0x10 returns 0x11AA3344.
- Halfword write 0xBEEF to 0x22 over 0 -> read of 0x20 returns 0xBEEF0000.
- MemRead=1 and MemWrite=01 together, data 0x5, address 0x4 -> write committed, ReadData keeps its previous value, single Ready pulse.
- Reset pulsed low in BUSY of a word write of 0x1 to 0x8 (location previously 0x0) -> Ready never pulses, Stall=0, a later read of 0x8 returns 0x0.
- Halfword write to 0x13:
  - With DMEM_MISALIGN_TRAP_EN: AlignErr=1 with Ready, memory unchanged.
  - Without it: data lands in bits 31:16 of word 0x10.
